// File: rtl/ioctl_load_sequencer_if.sv
// Download-side bus of ioctl_load_sequencer: hps_io ioctl byte stream in, ROM write strobes out.
// master = ioctl source / ROM sink, slave = the sequencer.
interface ioctl_load_sequencer_if #(
    parameter int unsigned ROM_AW = 16
) ();
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [2:0]        rom_we;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  rom_we,
        input  rom_addr,
        input  rom_data
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output rom_we,
        output rom_addr,
        output rom_data
    );
endinterface

// File: rtl/ioctl_load_sequencer.sv
// Splits the ioctl download stream into three ROM regions, mod-select and DIP registers, and owns core reset.
// Optional DL_CHECKSUM_EN adds rom_sum, a 16-bit wrapping sum of every byte written to ROM.
module ioctl_load_sequencer #(
    parameter int unsigned ROM_AW    = 16,
    parameter int unsigned R1_BASE   = 32'h2000,
    parameter int unsigned R2_BASE   = 32'hA000,
    parameter int unsigned DIP_BYTES = 8,
    parameter int unsigned HOLD_CYC  = 1024
) (
    input  logic                     clk_12,
    input  logic                     reset,
    input  logic                     ext_reset,
    ioctl_load_sequencer_if.slave    bus,
    output logic                     core_reset,
    output logic [3:0]               mod_onehot,
    output logic [8*DIP_BYTES-1:0]   dip_flat,
    output logic                     rom_overflow
`ifdef DL_CHECKSUM_EN
    ,
    output logic [15:0]              rom_sum
`endif
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYC);
    localparam logic [ROM_AW-1:0] R1_B      = ROM_AW'(R1_BASE);
    localparam logic [ROM_AW-1:0] R2_B      = ROM_AW'(R2_BASE);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_ROM = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             core_reset_reg;

    logic [2:0]        rom_we_reg;
    logic [ROM_AW-1:0] rom_addr_reg;
    logic [7:0]        rom_data_reg;
    logic              rom_overflow_reg;
    logic [3:0]        mod_onehot_reg;
    logic [7:0]        dip_reg [DIP_BYTES];

    // Write qualification: every strobe must fall inside an active download.
    logic              dl_wr;
    logic              rom_dl_req;
    logic              rom_sel;
    logic              mod_sel;
    logic              dip_sel;
    logic              addr_oob;
    logic              rom_hit;
    logic [ROM_AW-1:0] addr_lo;
    logic [2:0]        region_we;
    logic [ROM_AW-1:0] region_base;
    logic [3:0]        mod_decode;

    assign dl_wr      = bus.ioctl_wr & bus.ioctl_download;
    assign rom_dl_req = bus.ioctl_download && (bus.ioctl_index == 8'd0);
    assign rom_sel    = dl_wr && (bus.ioctl_index == 8'd0);
    assign mod_sel    = dl_wr && (bus.ioctl_index == 8'd1);
    assign dip_sel    = dl_wr && (bus.ioctl_index == 8'd254);
    assign addr_oob   = |bus.ioctl_addr[24:ROM_AW];
    assign rom_hit    = rom_sel && !addr_oob;
    assign addr_lo    = bus.ioctl_addr[ROM_AW-1:0];

    // Region boundaries belong to the higher region.
    always_comb begin
        region_we   = 3'b001;
        region_base = '0;
        if (addr_lo >= R2_B) begin
            region_we   = 3'b100;
            region_base = R2_B;
        end else if (addr_lo >= R1_B) begin
            region_we   = 3'b010;
            region_base = R1_B;
        end
    end

    always_comb begin
        mod_decode = 4'b0000;
        case (bus.ioctl_dout)
            8'd0:    mod_decode = 4'b0001;
            8'd1:    mod_decode = 4'b0010;
            8'd2:    mod_decode = 4'b0100;
            8'd3:    mod_decode = 4'b1000;
            default: mod_decode = 4'b0000;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (rom_dl_req) begin
                    state_next = LOAD_ROM;
                end else if (ext_reset) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end
            end
            LOAD_ROM: begin
                if (!bus.ioctl_download) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (rom_dl_req) begin
                    state_next = LOAD_ROM;
                end else if (ext_reset) begin
                    cnt_next   = HOLD_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next   = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = HOLD;
                cnt_next   = HOLD_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            state_reg      <= HOLD;
            cnt_reg        <= HOLD_LOAD;
            core_reset_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            core_reset_reg <= (state_next != RUN);
        end
    end

    // ROM address/data stay latched between strobes; only rom_we pulses.
    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            rom_we_reg       <= 3'b000;
            rom_addr_reg     <= '0;
            rom_data_reg     <= 8'd0;
            rom_overflow_reg <= 1'b0;
        end else begin
            rom_we_reg <= 3'b000;
            if (rom_sel) begin
                if (addr_oob) begin
                    rom_overflow_reg <= 1'b1;
                end else begin
                    rom_we_reg   <= region_we;
                    rom_addr_reg <= addr_lo - region_base;
                    rom_data_reg <= bus.ioctl_dout;
                end
            end
        end
    end

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            mod_onehot_reg <= 4'b0001;
        end else if (mod_sel) begin
            mod_onehot_reg <= mod_decode;
        end
    end

    generate
        for (genvar gi = 0; gi < DIP_BYTES; gi++) begin : g_dip
            always_ff @(posedge clk_12 or posedge reset) begin
                if (reset) begin
                    dip_reg[gi] <= 8'd0;
                end else if (dip_sel && (bus.ioctl_addr == 25'(gi))) begin
                    dip_reg[gi] <= bus.ioctl_dout;
                end
            end
            assign dip_flat[8*gi +: 8] = dip_reg[gi];
        end
    endgenerate

`ifdef DL_CHECKSUM_EN
    logic [15:0] sum_reg;
    logic        load_entry;

    // A write in the entry cycle is the first byte of the new sum.
    assign load_entry = (state_reg != LOAD_ROM) && (state_next == LOAD_ROM);

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            sum_reg <= 16'd0;
        end else begin
            sum_reg <= (load_entry ? 16'd0 : sum_reg) +
                       (rom_hit ? {8'd0, bus.ioctl_dout} : 16'd0);
        end
    end

    assign rom_sum = sum_reg;
`endif

    assign bus.rom_we    = rom_we_reg;
    assign bus.rom_addr  = rom_addr_reg;
    assign bus.rom_data  = rom_data_reg;
    assign core_reset    = core_reset_reg;
    assign mod_onehot    = mod_onehot_reg;
    assign rom_overflow  = rom_overflow_reg;

endmodule

// File: tb/tb_ioctl_load_sequencer.sv
// Directed bench for ioctl_load_sequencer: ROM writes are checked through a scoreboard queue,
// reset/hold timing, mod and DIP registers through immediate assertions.
module tb_ioctl_load_sequencer;

    localparam int HOLD_CYC = 1024;

    logic clk_12 = 1'b0;
    logic reset  = 1'b1;
    logic ext_reset = 1'b0;
    logic        core_reset;
    logic [3:0]  mod_onehot;
    logic [63:0] dip_flat;
    logic        rom_overflow;
`ifdef DL_CHECKSUM_EN
    logic [15:0] rom_sum;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0]  we;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t sb [$];

    ioctl_load_sequencer_if #(.ROM_AW(16)) bus ();

    ioctl_load_sequencer dut (
        .clk_12       (clk_12),
        .reset        (reset),
        .ext_reset    (ext_reset),
        .bus          (bus),
        .core_reset   (core_reset),
        .mod_onehot   (mod_onehot),
        .dip_flat     (dip_flat),
        .rom_overflow (rom_overflow)
`ifdef DL_CHECKSUM_EN
        ,
        .rom_sum      (rom_sum)
`endif
    );

    always #5 clk_12 = ~clk_12;

    always @(posedge clk_12) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rom_we pulse must match the oldest pending write, one cycle after its strobe.
    always @(negedge clk_12) begin
        if (bus.rom_we !== 3'b000) begin
            if (sb.size() == 0) begin
                check("rom_we_spurious", {61'd0, bus.rom_we}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rom_we",    {61'd0, bus.rom_we},   {61'd0, e.we});
                check("rom_addr",  {48'd0, bus.rom_addr}, {48'd0, e.addr});
                check("rom_data",  {56'd0, bus.rom_data}, {56'd0, e.data});
                check("rom_cycle", 64'(cyc),             64'(e.cyc));
            end
        end
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the edge that samples the strobe.
    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        bus.ioctl_index = idx;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = data;
        bus.ioctl_wr    = 1'b1;
        @(posedge clk_12); #1;
        bus.ioctl_wr    = 1'b0;
    endtask

    task automatic rom_wr(input logic [24:0] addr, input logic [7:0] data,
                          input logic [2:0] exp_we, input logic [15:0] exp_addr);
        exp_t e;
        e.we   = exp_we;
        e.addr = exp_addr;
        e.data = data;
        e.cyc  = cyc + 1;
        sb.push_back(e);
        wr_byte(8'd0, addr, data);
        @(posedge clk_12); #1;
    endtask

    // Counts consecutive post-edge samples with core_reset high, bounded.
    task automatic count_hold(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_12); #1;
            if (core_reset !== 1'b1) break;
            n++;
        end
    endtask

    initial begin
        int n;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;

        // Reset values
        repeat (3) @(posedge clk_12);
        #1;
        check("rst_core_reset",   {63'd0, core_reset},   64'd1);
        check("rst_mod_onehot",   {60'd0, mod_onehot},   64'd1);
        check("rst_dip_flat",     dip_flat,              64'd0);
        check("rst_rom_overflow", {63'd0, rom_overflow}, 64'd0);
        check("rst_rom_we",       {61'd0, bus.rom_we},   64'd0);
        check("rst_rom_addr",     {48'd0, bus.rom_addr}, 64'd0);
        check("rst_rom_data",     {56'd0, bus.rom_data}, 64'd0);

        // Hold window after reset release
        @(negedge clk_12) reset = 1'b0;
        count_hold(n);
        check("hold_after_reset", 64'(n), 64'(HOLD_CYC));
        check("mod_after_hold", {60'd0, mod_onehot}, 64'd1);

        // Strobe without download is ignored, even out of range
        wr_byte(8'd0, 25'h10000, 8'hAA);
        @(posedge clk_12); #1;
        check("nodl_overflow",   {63'd0, rom_overflow}, 64'd0);
        check("nodl_core_reset", {63'd0, core_reset},   64'd0);

        // ROM download across region boundaries
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        rom_wr(25'h01FFF, 8'hA1, 3'b001, 16'h1FFF);
        check("dl_core_reset", {63'd0, core_reset}, 64'd1);
        rom_wr(25'h02000, 8'hB2, 3'b010, 16'h0000);
        rom_wr(25'h0A000, 8'hC3, 3'b100, 16'h0000);
        rom_wr(25'h0FFFF, 8'hD4, 3'b100, 16'h5FFF);
        rom_wr(25'h0FFFE, 8'hE5, 3'b100, 16'h5FFE);
        wr_byte(8'd0, 25'h10000, 8'h99);
        @(posedge clk_12); #1;
        check("overflow_set", {63'd0, rom_overflow}, 64'd1);
        bus.ioctl_download = 1'b0;
        @(posedge clk_12); #1;  // edge that registers the end of the download
        count_hold(n);
        check("hold_after_dl", 64'(n), 64'(HOLD_CYC));
        check("overflow_sticky", {63'd0, rom_overflow}, 64'd1);

        // DIP bytes serviced in RUN
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd254;
        wr_byte(8'd254, 25'd0, 8'h12);
        wr_byte(8'd254, 25'd7, 8'h34);
        wr_byte(8'd254, 25'd8, 8'h55);
        check("dip_flat", dip_flat, 64'h3400_0000_0000_0012);
        wr_byte(8'd254, 25'd0, 8'h56);
        check("dip_overwrite", dip_flat, 64'h3400_0000_0000_0056);
        check("dip_core_reset", {63'd0, core_reset}, 64'd0);

        // Mod select
        bus.ioctl_index = 8'd1;
        wr_byte(8'd1, 25'd0, 8'h02);
        check("mod_02", {60'd0, mod_onehot}, 64'b0100);
        wr_byte(8'd1, 25'd0, 8'h07);
        check("mod_07", {60'd0, mod_onehot}, 64'b0000);
        wr_byte(8'd1, 25'd0, 8'h03);
        check("mod_03", {60'd0, mod_onehot}, 64'b1000);

        // Unused index changes nothing
        bus.ioctl_index = 8'd5;
        wr_byte(8'd5, 25'd0, 8'h01);
        @(posedge clk_12); #1;
        check("idx5_core_reset", {63'd0, core_reset}, 64'd0);
        check("idx5_mod",        {60'd0, mod_onehot}, 64'b1000);
        check("idx5_dip",        dip_flat, 64'h3400_0000_0000_0056);
        bus.ioctl_download = 1'b0;

        // External reset request
        ext_reset = 1'b1;
        @(posedge clk_12); #1;
        check("ext_core_reset", {63'd0, core_reset}, 64'd1);
        repeat (20) @(posedge clk_12);
        #1;
        ext_reset = 1'b0;
        count_hold(n);
        check("hold_after_ext", 64'(n), 64'(HOLD_CYC));

        // Async reset in the middle of a download
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        for (int i = 0; i < 100; i++) begin
            rom_wr(25'(i), 8'(i), 3'b001, 16'(i));
        end
        wr_byte(8'd0, 25'd100, 8'h64);
        check("byte100_rom_we", {61'd0, bus.rom_we}, 64'b001);
        #1 reset = 1'b1;
        #1;
        check("areset_rom_we",     {61'd0, bus.rom_we},   64'd0);
        check("areset_rom_addr",   {48'd0, bus.rom_addr}, 64'd0);
        check("areset_core_reset", {63'd0, core_reset},   64'd1);
        check("areset_mod",        {60'd0, mod_onehot},   64'd1);
        check("areset_dip",        dip_flat,              64'd0);
        check("areset_overflow",   {63'd0, rom_overflow}, 64'd0);
        bus.ioctl_download = 1'b0;
        repeat (2) @(posedge clk_12);
        @(negedge clk_12) reset = 1'b0;
        count_hold(n);
        check("hold_after_areset", 64'(n), 64'(HOLD_CYC));

`ifdef DL_CHECKSUM_EN
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        rom_wr(25'd0, 8'hFF, 3'b001, 16'd0);
        rom_wr(25'd1, 8'h01, 3'b001, 16'd1);
        rom_wr(25'd2, 8'h10, 3'b001, 16'd2);
        bus.ioctl_download = 1'b0;
        @(posedge clk_12); #1;
        check("rom_sum", {48'd0, rom_sum}, 64'h0110);
`endif

        repeat (3) @(posedge clk_12);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioctl_load_sequencer.md
Name: ioctl_load_sequencer

Overview:
- Sits between hps_io download outputs and the game core.
- Sequences the ioctl stream into three ROM regions, the mod-select byte (index 1) and DIP bytes (index 254).
- Owns core reset: holds it during ROM download and for a fixed post-load window.
- Single source of truth for the mod one-hot and DIP registers.

Parameters:
- ROM_AW, 16, ROM byte address width accepted from ioctl_addr.
- R1_BASE, 16'h2000, first address of region 1 (program ROM). Region 0 is vector ROM [0, R1_BASE).
- R2_BASE, 16'hA000, first address of region 2 (sound/PROM). Region 1 is [R1_BASE, R2_BASE); region 2 is [R2_BASE, 2^ROM_AW).
- DIP_BYTES, 8, number of DIP bytes captured.
- HOLD_CYC, 1024, core reset hold cycles after a load or reset ends (≥1).

Ports:
- clk_12  in  1  system clock (hps_io domain)
- reset  in  1  async active-high reset
- ext_reset  in  1  OSD/button reset request, level
- ioctl_download  in  1  download active
- ioctl_index  in  8  download target index
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- rom_we  out  3  one-hot region write strobe
- rom_addr  out  ROM_AW  address relative to region base
- rom_data  out  8  write data
- core_reset  out  1  active-high reset to game core
- mod_onehot  out  4  {spacduel, lunarbat, gravitar, bwidow}
- dip_flat  out  8*DIP_BYTES  byte k at bits [8k+7:8k]
- rom_overflow  out  1  sticky: ROM byte dropped, address out of range

Behaviour:
- Reset values:
  - rom_we=0, rom_addr=0, rom_data=0.
  - core_reset=1, mod_onehot=4'b0001, dip_flat=0, rom_overflow=0.
  - State=HOLD with counter=HOLD_CYC.
- States:
  - RUN: core_reset=0. ioctl_download & index==0 → LOAD_ROM. ext_reset → HOLD (counter reloaded). Index 1/254 writes are serviced in RUN without changing state.
  - LOAD_ROM: core_reset=1. Falling ioctl_download → HOLD, counter=HOLD_CYC.
  - HOLD: core_reset=1. Counter decrements each cycle; at 0 → RUN.
    - ext_reset or a new index-0 download reloads or leaves as in RUN.
    - ext_reset held high keeps the block in HOLD with counter at HOLD_CYC.
- core_reset is registered and asserts the cycle after entering LOAD_ROM or HOLD. It releases on the cycle after the counter reaches 0: exactly HOLD_CYC cycles of hold after download falls.
- ROM write path, registered, 1-cycle latency: ioctl_wr & download & index==0 in cycle N → rom_we/rom_addr/rom_data valid in N+1 for exactly one cycle.
  - Region chosen by addr versus R1_BASE/R2_BASE (boundaries belong to the higher region).
  - rom_addr = ioctl_addr minus the region base.
- Addresses with ioctl_addr[24:ROM_AW]≠0 produce no rom_we and set rom_overflow. rom_overflow clears only on reset.
- Index 1: every write updates a mod byte; mod_onehot is decoded and registered the next cycle.
  - Values 0..3 map to bits 0..3.
  - Values ≥4 give 4'b0000; the core treats this as no game.
- Index 254: writes with addr<DIP_BYTES store the byte into dip_flat in the next cycle. Higher addresses are ignored. Later writes to the same address overwrite.
- Other indices are ignored entirely and cause no state change.
- ioctl_wr without ioctl_download is ignored.
- Async reset mid-download: all outputs go to reset values immediately. After release, the block runs the HOLD window. Partially written ROM content is not tracked.

Optional Feature:
- Macro: DL_CHECKSUM_EN.
- Defined:
  - Adds output rom_sum[15:0], the 16-bit wrapping sum of every byte that produced a rom_we.
  - Cleared on entry to LOAD_ROM and on reset.
  - Valid and stable from the first HOLD cycle onward.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Reset then idle → core_reset=1 for HOLD_CYC=1024 cycles after reset falls; mod_onehot=0001; rom_we never pulses.
- Index-0 download, bytes at 0x1FFF, 0x2000, 0xA000, 0xFFFF:
  - rom_we = 001, 010, 100, 100, each one cycle after ioctl_wr.
  - rom_addr = 0x1FFF, 0x0000, 0x0000, 0x5FFF.
  - core_reset high throughout and for 1024 cycles after download falls.
- Index-0 write at addr 0x10000 → no rom_we, rom_overflow=1 and stays set.
- Index-254 writes 0x12@0, 0x34@7, 0x55@8 → dip_flat[7:0]=0x12, dip_flat[63:56]=0x34, other bytes 0; core_reset unaffected.
- Index-1 write 0x02 → mod_onehot=0100 next cycle; write 0x07 → 0000.
- Async reset asserted mid-download at byte 100 → rom_we=0 and core_reset=1 immediately; after release, 1024 hold cycles then RUN. With DL_CHECKSUM_EN, a download of 0xFF,0x01,0x10 gives rom_sum=0x0110.
